// File: rtl/unsigned_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// unsigned_shift_add_multiplier
//
// Sequential radix-2 unsigned multiplier. An accepted start latches operand A
// into an internal register and loads the multiplier B into the low half of
// the product register. Each CALC cycle conditionally adds A into the high
// half and shifts the whole product right by one, keeping the adder carry.
// WIDTH iterations later the exact 2*WIDTH-bit product is left in place.
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   begin a multiply (honoured in IDLE and DONE only)
//   multiplicand  in   WIDTH-bit operand A, sampled at the accepting edge
//   multiplier    in   WIDTH-bit operand B, sampled at the accepting edge
//   product       out  2*WIDTH-bit result register (valid from done onward)
//   busy          out  high exactly while iterating (CALC)
//   done          out  one-cycle pulse while in DONE
//   state_o       out  debug view of the FSM state register
//
// Handshake: start is a level sampled on each rising clk edge. It is
// accepted only when busy=0 (IDLE or DONE); in CALC it is ignored, never
// queued. done is a single-cycle strobe; product is stable from the done
// cycle until the next accepting edge.
// ---------------------------------------------------------------------------
module unsigned_shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_o
);

  // Iteration counter is wide enough to hold WIDTH itself.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [CW-1:0]      count_q, count_d;

  // One shift-add step: the adder is WIDTH+1 bits so its carry becomes the
  // new MSB of the product after the right shift; nothing is ever dropped.
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;

  always_comb begin
    addend = '0;
    if (product_q[0]) begin
      addend = {1'b0, mcand_q};
    end
    sum = {1'b0, product_q[2*WIDTH-1:WIDTH]} + addend;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    count_d   = count_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d   = multiplicand;
          product_d = {{WIDTH{1'b0}}, multiplier};
          count_d   = '0;
          state_d   = CALC;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      CALC: begin
        product_d = {sum, product_q[WIDTH-1:1]};
        count_d   = count_q + 1'b1;
        // This edge performs iteration number WIDTH.
        if (count_q == LAST_ITER) begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      product_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      count_q   <= count_d;
    end
  end

  // Outputs decode straight from registers, so they move only on clk edges.
  assign product = product_q;
  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_unsigned_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// Testbench for unsigned_shift_add_multiplier (WIDTH=32).
// Directed scenarios followed by randomized operand pairs; expected products
// come from plain 64-bit arithmetic and expected timing from the documented
// latency (done appears WIDTH edges after the accepting edge).
// ---------------------------------------------------------------------------
module tb_unsigned_shift_add_multiplier;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;
  logic [1:0]     state_o;

  always #5 clk = ~clk;

  unsigned_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done),
    .state_o      (state_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] wa, wb;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    return wa * wb;
  endfunction

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock and settle 1 time unit past the edge; all sampling and
  // driving happens here, well clear of the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one edge and queue the answer.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    exp_q.push_back(ref_mul(a, b));
    step();
    start = 1'b0;
  endtask

  // Wait (bounded) for done. 'pre' is how many edges after the accepting
  // edge have already been taken. With noise, inputs are scrambled and start
  // is toggled while busy -- none of that may affect the result.
  task automatic wait_done(input string tag, input bit noise, input int pre);
    int cnt;
    int busy_cnt;
    int overlap;
    logic [2*W-1:0] exp;
    cnt = pre;
    busy_cnt = pre;
    overlap = 0;
    while (done !== 1'b1 && cnt < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && done === 1'b1) overlap++;
      if (noise && busy === 1'b1) begin
        start        = 1'($urandom_range(0, 1));
        multiplicand = $urandom;
        multiplier   = $urandom;
      end
      step();
      cnt++;
    end
    start = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_latency"}, 64'(cnt), 64'(W));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({tag, "_busy_done_overlap"}, 64'(overlap) + 64'(busy), 64'd0);
    check({tag, "_product"}, product, exp);
  endtask

  // Cycle after done with start low: back to idle, product held.
  task automatic check_after(input string tag, input logic [2*W-1:0] exp);
    step();
    check({tag, "_post_done"}, 64'(done), 64'd0);
    check({tag, "_post_busy"}, 64'(busy), 64'd0);
    check({tag, "_post_hold"}, product, exp);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] a, b;
    int done_seen;

    // Reset for two cycles.
    rst = 1'b1;
    step();
    step();
    check("reset_product", product, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst = 1'b0;
    step();
    check("idle_no_start_busy", 64'(busy), 64'd0);

    // Basic multiply 3*5.
    launch(32'd3, 32'd5);
    check("basic_busy_after_accept", 64'(busy), 64'd1);
    wait_done("basic", 1'b0, 0);
    check("basic_value", product, 64'h0000_0000_0000_000F);
    check_after("basic", 64'h0000_0000_0000_000F);

    // rst toggling between clk edges must not move any output.
    rst = 1'b1;
    #2;
    check("rst_async_product", product, 64'h0000_0000_0000_000F);
    check("rst_async_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Maximum operands: carry out of the adder must survive.
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("max", 1'b0, 0);
    check("max_value", product, 64'hFFFF_FFFE_0000_0001);
    check_after("max", 64'hFFFF_FFFE_0000_0001);

    // Zero operands.
    launch(32'h1234_5678, 32'd0);
    wait_done("zero_b", 1'b0, 0);
    check_after("zero_b", 64'd0);
    launch(32'd0, 32'hFFFF_FFFF);
    wait_done("zero_a", 1'b0, 0);
    check_after("zero_a", 64'd0);

    // Start while busy: second request at iteration 10 is ignored.
    launch(32'd7, 32'd9);
    repeat (9) step();
    multiplicand = 32'd2;
    multiplier   = 32'd2;
    start        = 1'b1;
    step();
    start = 1'b0;
    wait_done("start_busy", 1'b0, 10);
    check("start_busy_value", product, 64'd63);
    check_after("start_busy", 64'd63);

    // Reset mid-operation at iteration 16: abort, no done pulse.
    launch(32'hDEAD_BEEF, 32'h0BAD_F00D);
    void'(exp_q.pop_back());
    repeat (16) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_product", product, 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen++;
      step();
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);

    // First start after reset, then back-to-back restart from DONE.
    launch(32'h0001_0000, 32'h0001_0000);
    wait_done("big", 1'b0, 0);
    check("big_value", product, 64'h0000_0001_0000_0000);
    launch(32'd6, 32'd7);
    check("b2b_reenter_busy", 64'(busy), 64'd1);
    check("b2b_reenter_done", 64'(done), 64'd0);
    wait_done("b2b", 1'b0, 0);
    check("b2b_value", product, 64'd42);
    check_after("b2b", 64'd42);

    // Random operand pairs, with input noise while busy and random
    // back-to-back restarts straight from DONE.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0: a = '0;
        1: a = '1;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        default: b = $urandom;
      endcase
      launch(a, b);
      wait_done("rand", 1'b1, 0);
      if ($urandom_range(0, 3) == 0) begin
        step();
        check("rand_idle_done", 64'(done), 64'd0);
      end
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/unsigned_shift_add_multiplier.md
UNSIGNED_SHIFT_ADD_MULTIPLIER -- requirements
Module: unsigned_shift_add_multiplier

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, the operand width in bits; WIDTH SHALL be a power of two, 4 or greater.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-005 The block SHALL have port multiplicand, input, WIDTH bits: unsigned operand A.
REQ-006 The block SHALL have port multiplier, input, WIDTH bits: unsigned operand B.
REQ-007 The block SHALL have port product, output, 2*WIDTH bits: registered result A*B.
REQ-008 The block SHALL have port busy, output, 1 bit: high while iterating.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking product valid.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-011 In IDLE or DONE, a rising clk edge with start=1 and rst=0 SHALL perform all of the following:
- accept the request;
- latch multiplicand into an internal WIDTH-bit register;
- load product with {WIDTH zeros, multiplier};
- clear the iteration counter;
- enter CALC.
REQ-012 multiplicand and multiplier SHALL be sampled only at the accepting edge; changes at any other time SHALL have no effect.
REQ-013 Each clk edge in CALC SHALL perform exactly one iteration:
- if product[0]=1: sum = product[2W-1:W] + A, computed WIDTH+1 bits wide with the carry kept; otherwise sum = {1'b0, product[2W-1:W]};
- product <= {sum, product[W-1:1]}, a logical right shift that brings the carry in.
REQ-014 The iteration counter SHALL be log2(WIDTH)+1 bits wide and increment once per CALC edge.
REQ-015 The FSM SHALL move from CALC to DONE on the edge that performs iteration number WIDTH.
REQ-016 DONE SHALL last exactly one cycle.
REQ-017 From DONE, the FSM SHALL go to IDLE if start=0, or to CALC per REQ-011 if start=1.
REQ-018 Latency: if start is accepted at edge E0, done SHALL be high in the cycle after edge E(WIDTH), which is 32 cycles for WIDTH=32.
REQ-019 busy SHALL be 1 exactly while the state is CALC, and done SHALL be 1 exactly while the state is DONE.
REQ-020 busy and done SHALL never be high in the same cycle.
REQ-021 start while in CALC SHALL be ignored, with no restart and no queuing.
REQ-022 product SHALL show intermediate values during CALC and SHALL be valid only from the done cycle onward.
REQ-023 product SHALL hold its final value in DONE and IDLE until the next accepting edge.
REQ-024 The result SHALL be exact for all operand pairs: no overflow is possible, and the carry out of the WIDTH+1-bit sum SHALL never be dropped.

Reset
REQ-025 rst=1 at a rising clk edge SHALL force all of the following, regardless of start:
- state IDLE;
- product 0;
- internal multiplicand register 0;
- counter 0;
- busy 0;
- done 0.
REQ-026 rst SHALL take priority over start and over any iteration in progress.
REQ-027 A reset during CALC SHALL abort the operation with no done pulse.
REQ-028 No output SHALL change on any edge of rst; changes SHALL occur only on clk edges.
REQ-029 After reset deasserts, the first accepting edge SHALL behave exactly as in REQ-011.

Verification
REQ-030 Basic multiply: rst for 2 cycles, then start with A=3, B=5 -> busy high for 32 cycles, then done=1 for one cycle with product=0x0000_0000_0000_000F, then busy=0 and done=0.
REQ-031 Maximum operands: A=B=0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001 at done, which exercises the carry in REQ-013.
REQ-032 Zero operand: A=0x1234_5678, B=0 -> product=0 at done; with A=0 and B=0xFFFF_FFFF -> product=0.
REQ-033 Start while busy: start A=7, B=9, then pulse start with A=2, B=2 at CALC iteration 10 -> done still at cycle 32 after the first start, with product=63 (0x3F).
REQ-034 Reset mid-operation and back-to-back:
- assert rst at CALC iteration 16 -> next cycle product=0, busy=0, done=0, and no done pulse follows;
- start A=0x10000, B=0x10000 -> product=0x1_0000_0000;
- hold start high through DONE with A=6, B=7 -> CALC re-entered directly, and the next done shows product=42.
REQ-035 The bench SHALL also run at least 1000 random operand pairs against a golden 64-bit product, checking the done spacing of REQ-018.
